// File: rtl/hpdcache_pkg.sv
`default_nettype none
// ============================================================================
// hpdcache_pkg : shared types for the HPDcache request arbiters
// Revision 1.0
// ============================================================================
package hpdcache_pkg;

    typedef enum logic {
        HPDCACHE_ARB_FIXED = 1'b0,
        HPDCACHE_ARB_RR    = 1'b1
    } hpdcache_arb_mode_e;

endpackage
`default_nettype wire

// File: rtl/hpdcache_prio_1hot_encoder.sv
`default_nettype none
// ============================================================================
// hpdcache_prio_1hot_encoder : keeps only the lowest set bit of the input
// Revision 1.0
// ============================================================================
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    // Two's complement isolates the least significant set bit.
    assign val_o = val_i & (-val_i);

endmodule
`default_nettype wire

// File: rtl/hpdcache_mxarb.sv
`default_nettype none
// ============================================================================
// hpdcache_mxarb : fixed-priority / round-robin arbiter with grant hold and
//                  optional anti-starvation promotion
// Revision 1.0
// ============================================================================
module hpdcache_mxarb
    import hpdcache_pkg::*;
#(
    parameter int unsigned N            = 2,
    parameter int unsigned STARVE_LIMIT = 0,
    parameter int unsigned IDXW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  hpdcache_arb_mode_e mode_i,
    input  logic [N-1:0]       req_i,
    input  logic               ready_i,
    output logic [N-1:0]       gnt_o,
    output logic [IDXW-1:0]    gnt_idx_o,
    output logic               gnt_valid_o
);

    logic            r_wait;
    logic [N-1:0]    r_gnt;
    logic [IDXW-1:0] r_ptr;
    logic [N-1:0]    w_starved;
    logic [N-1:0]    w_starve_gnt;
    logic [N-1:0]    w_fix_gnt;
    logic [N-1:0]    w_rr_gnt;
    logic [IDXW-1:0] w_idx;
    logic            w_accept;

    assign w_accept = gnt_valid_o & ready_i;

    hpdcache_prio_1hot_encoder #(.N(N)) u_enc_fix (
        .val_i (req_i),
        .val_o (w_fix_gnt)
    );

    hpdcache_prio_1hot_encoder #(.N(N)) u_enc_starve (
        .val_i (w_starved),
        .val_o (w_starve_gnt)
    );

    generate
        if (N > 1) begin : g_rr
            logic [N-1:0]   w_lo_mask;
            logic [2*N-1:0] w_rr_vec;
            logic [2*N-1:0] w_rr_1hot;

            always_comb begin
                w_lo_mask = '0;
                for (int i = 0; i < N; i++) begin
                    w_lo_mask[i] = (IDXW'(i) < r_ptr);
                end
            end

            // Low half holds requests at/after the pointer; the upper copy
            // supplies the wrapped-around winner when the low half is empty.
            assign w_rr_vec = {req_i, req_i & ~w_lo_mask};

            hpdcache_prio_1hot_encoder #(.N(2*N)) u_enc_rr (
                .val_i (w_rr_vec),
                .val_o (w_rr_1hot)
            );

            assign w_rr_gnt = w_rr_1hot[N-1:0] | w_rr_1hot[2*N-1:N];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_ptr <= '0;
                end else if (w_accept) begin
                    r_ptr <= (w_idx == IDXW'(N-1)) ? '0 : w_idx + 1'b1;
                end
            end
        end else begin : g_no_rr
            assign w_rr_gnt = req_i;
            assign r_ptr    = '0;
        end
    endgenerate

    generate
        if (STARVE_LIMIT > 0) begin : g_age
            localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
            localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);
            logic [CW-1:0] r_cnt [N];

            always_comb begin
                w_starved = '0;
                for (int i = 0; i < N; i++) begin
                    w_starved[i] = req_i[i] && (r_cnt[i] == C_LIMIT);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < N; i++) r_cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (!req_i[i] || (w_accept && gnt_o[i])) begin
                            r_cnt[i] <= '0;
                        end else if (w_accept && (r_cnt[i] != C_LIMIT)) begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_age
            assign w_starved = '0;
        end
    endgenerate

    always_comb begin
        if (r_wait) begin
            gnt_o = r_gnt;
        end else if (|w_starved) begin
            gnt_o = w_starve_gnt;
        end else if (mode_i == HPDCACHE_ARB_RR) begin
            gnt_o = w_rr_gnt;
        end else begin
            gnt_o = w_fix_gnt;
        end
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) w_idx = w_idx | IDXW'(i);
        end
    end

    assign gnt_idx_o   = (N > 1) ? w_idx : '0;
    assign gnt_valid_o = |gnt_o;

    // A grant not taken immediately is frozen until the consumer accepts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= 1'b0;
            r_gnt  <= '0;
        end else if (w_accept) begin
            r_wait <= 1'b0;
            r_gnt  <= '0;
        end else if (gnt_valid_o && !r_wait) begin
            r_wait <= 1'b1;
            r_gnt  <= gnt_o;
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_gnt_q_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_wait |=> (!r_wait || $stable(r_gnt)));
    a_idx_consistent : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_o == '0) ? (gnt_idx_o == '0) : gnt_o[gnt_idx_o]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mxarb.sv
`default_nettype none
// Directed self-checking bench for hpdcache_mxarb: one plain-RR/fixed
// instance and one with aging enabled, sharing the same stimulus.
module tb_hpdcache_mxarb;
    import hpdcache_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    hpdcache_arb_mode_e mode;
    logic [3:0]         req;
    logic               ready;
    logic [3:0]         gnt,     gnt_a;
    logic [1:0]         idx,     idx_a;
    logic               gvalid,  gvalid_a;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hpdcache_mxarb #(.N(4), .STARVE_LIMIT(0)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_i      (mode),
        .req_i       (req),
        .ready_i     (ready),
        .gnt_o       (gnt),
        .gnt_idx_o   (idx),
        .gnt_valid_o (gvalid)
    );

    hpdcache_mxarb #(.N(4), .STARVE_LIMIT(2)) dut_age (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_i      (mode),
        .req_i       (req),
        .ready_i     (ready),
        .gnt_o       (gnt_a),
        .gnt_idx_o   (idx_a),
        .gnt_valid_o (gvalid_a)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        mode  = HPDCACHE_ARB_FIXED;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        mode  = HPDCACHE_ARB_FIXED;
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, idx, gvalid} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_idle: got gnt=%b idx=%0d v=%b exp 0000/0/0", gnt, idx, gvalid);
        end
        mode = HPDCACHE_ARB_RR;
        req  = 4'b0110;
        #1;
        n_cmp++;
        if (gnt !== 4'b0010 || idx !== 2'd1) begin
            n_err++;
            $display("FAIL reset_rr_comb: got gnt=%b idx=%0d exp 0010/1", gnt, idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mode = HPDCACHE_ARB_FIXED; req = 4'b1010; ready = 1'b1;
            #1;
            n_cmp++;
            if (gnt !== 4'b0010 || idx !== 2'd1 || gvalid !== 1'b1) begin
                n_err++;
                $display("FAIL fixed_gnt c%0d: got gnt=%b idx=%0d v=%b exp 0010/1/1", c, gnt, idx, gvalid);
            end
        end
        // pointer should now be 2: RR with all requesting picks index 2
        @(negedge clk);
        mode = HPDCACHE_ARB_RR; req = 4'b1111; ready = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0100 || idx !== 2'd2) begin
            n_err++;
            $display("FAIL fixed_ptr: got gnt=%b idx=%0d exp 0100/2", gnt, idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mode = HPDCACHE_ARB_RR; req = 4'b1111; ready = 1'b1;
            #1;
            n_cmp++;
            if (gnt !== exp_g[c] || idx !== 2'(c % 4)) begin
                n_err++;
                $display("FAIL rr_b2b c%0d: got gnt=%b idx=%0d exp %b/%0d", c, gnt, idx, exp_g[c], c % 4);
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mode = HPDCACHE_ARB_FIXED; req = 4'b0100; ready = 1'b0;
            #1;
            n_cmp++;
            if (gnt !== 4'b0100 || idx !== 2'd2) begin
                n_err++;
                $display("FAIL hold_wait c%0d: got gnt=%b idx=%0d exp 0100/2", c, gnt, idx);
            end
        end
        @(negedge clk);
        req = 4'b0001;
        #1;
        n_cmp++;
        if (gnt !== 4'b0100 || gvalid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_reqdrop: got gnt=%b v=%b exp 0100/1", gnt, gvalid);
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL hold_accept: got gnt=%b exp 0100", gnt);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (gnt !== 4'b0001 || idx !== 2'd0) begin
            n_err++;
            $display("FAIL hold_release: got gnt=%b idx=%0d exp 0001/0", gnt, idx);
        end
    endtask

    task automatic test_starve();
        logic [3:0] exp_a [6] = '{4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b1000};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mode = HPDCACHE_ARB_FIXED; req = 4'b1001; ready = 1'b1;
            #1;
            n_cmp++;
            if (gnt_a !== exp_a[c]) begin
                n_err++;
                $display("FAIL starve_age c%0d: got gnt=%b exp %b", c, gnt_a, exp_a[c]);
            end
            n_cmp++;
            if (gnt !== 4'b0001) begin
                n_err++;
                $display("FAIL starve_noage c%0d: got gnt=%b exp 0001", c, gnt);
            end
        end
    endtask

    task automatic test_mode_switch();
        apply_reset();
        @(negedge clk);
        mode = HPDCACHE_ARB_FIXED; req = 4'b0100; ready = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL switch_first: got gnt=%b exp 0100", gnt);
        end
        @(negedge clk);
        mode = HPDCACHE_ARB_RR; req = 4'b0111;
        #1;
        n_cmp++;
        if (gnt !== 4'b0001 || idx !== 2'd0) begin
            n_err++;
            $display("FAIL switch_wrap: got gnt=%b idx=%0d exp 0001/0", gnt, idx);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        mode = HPDCACHE_ARB_FIXED; req = 4'b0010; ready = 1'b0;
        @(negedge clk);
        req = 4'b1000;
        #1;
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL areset_held: got gnt=%b exp 0010", gnt);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b1000 || idx !== 2'd3 || gvalid !== 1'b1) begin
            n_err++;
            $display("FAIL areset_drop: got gnt=%b idx=%0d v=%b exp 1000/3/1", gnt, idx, gvalid);
        end
        mode = HPDCACHE_ARB_RR; req = 4'b1111;
        #1;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL areset_ptr: got gnt=%b exp 0001", gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed();
        test_back_to_back();
        test_hold();
        test_starve();
        test_mode_switch();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
